// File: rtl/adder_acc.sv
// adder_acc: registered signed add/sub with a saturating or wrapping
// accumulator, sticky overflow flag and an accepted-operation counter.
module adder_acc #(
  parameter int WIDTH  = 4,
  parameter int SAT_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH:0]   C,
  output logic             out_valid,
  output logic             ovf,
  output logic [7:0]       op_cnt
);

  logic [WIDTH:0]   c_q, c_d;
  logic             vld_q, vld_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       cnt_q, cnt_d;

  logic [WIDTH:0]   a_ext, b_ext;
  logic [WIDTH:0]   res_max, res_min;
  logic [WIDTH+1:0] acc_sum;
  logic             acc_ovf;
  logic             is_add, is_sub, is_acc, is_clr;

  assign a_ext   = {A[WIDTH-1], A};
  assign b_ext   = {B[WIDTH-1], B};
  assign res_max = {1'b0, {WIDTH{1'b1}}};
  assign res_min = {1'b1, {WIDTH{1'b0}}};

  // Accumulate one bit wider than C so out-of-range sums are visible
  // as a disagreement between the two top bits.
  assign acc_sum = {a_ext[WIDTH], a_ext} + {c_q[WIDTH], c_q};
  assign acc_ovf = acc_sum[WIDTH+1] ^ acc_sum[WIDTH];

  assign is_add = (op == 2'b00);
  assign is_sub = (op == 2'b01);
  assign is_acc = (op == 2'b10);
  assign is_clr = (op == 2'b11);

  // Next-state for result, flags and counter; everything holds when idle.
  always_comb begin
    c_d   = c_q;
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    vld_d = 1'b0;
    if (in_valid) begin
      vld_d = 1'b1;
      cnt_d = cnt_q + 8'd1;
      unique case (1'b1)
        is_add: c_d = a_ext + b_ext;
        is_sub: c_d = a_ext - b_ext;
        is_acc: begin
          c_d = acc_sum[WIDTH:0];
          if (acc_ovf) begin
            ovf_d = 1'b1;
            if (SAT_EN != 0) begin
              c_d = acc_sum[WIDTH+1] ? res_min : res_max;
            end
          end
        end
        is_clr: begin
          c_d   = '0;
          ovf_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // State registers; reset clears everything without waiting for clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_q   <= '0;
      vld_q <= 1'b0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      c_q   <= c_d;
      vld_q <= vld_d;
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
    end
  end

  assign C         = c_q;
  assign out_valid = vld_q;
  assign ovf       = ovf_q;
  assign op_cnt    = cnt_q;

endmodule

// File: doc/adder_acc.md
ADDER_ACC -- requirements
Module: adder_acc

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand width in bits (2..32).
REQ-002 SHALL have parameter SAT_EN, default 1; 1 = accumulate saturates, 0 = accumulate wraps.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operation request qualifier.
REQ-006 SHALL have port op  input  2  operation: 00 ADD, 01 SUB, 10 ACC, 11 CLR.
REQ-007 SHALL have port A  input  WIDTH  signed operand A.
REQ-008 SHALL have port B  input  WIDTH  signed operand B; used by ADD/SUB only.
REQ-009 SHALL have port C  output  WIDTH+1  signed registered result/accumulator.
REQ-010 SHALL have port out_valid  output  1  C updated by op sampled on previous edge.
REQ-011 SHALL have port ovf  output  1  sticky accumulate overflow flag.
REQ-012 SHALL have port op_cnt  output  8  count of accepted operations.

Function
REQ-013 SHALL sample in_valid, op, A, B on rising clk; result visible on C one cycle later (latency 1, throughput 1/cycle).
REQ-014 SHALL, for ADD, load C <= sign-extended A + B; no overflow possible at WIDTH+1.
REQ-015 SHALL, for SUB, load C <= sign-extended A - B; no overflow possible at WIDTH+1.
REQ-016 SHALL, for ACC, compute C + sign-extended A in WIDTH+2 bits, then load C with the result.
REQ-017 SHALL, for ACC with SAT_EN=1, clamp to MAX = 2^WIDTH-1 or MIN = -2^WIDTH when out of range, and set ovf.
REQ-018 SHALL, for ACC with SAT_EN=0, keep the low WIDTH+1 bits (two's-complement wrap), and set ovf on wrap.
REQ-019 SHALL, for CLR, load C <= 0 and ovf <= 0.
REQ-020 SHALL clear ovf only on reset or CLR; ADD/SUB leave ovf unchanged.
REQ-021 SHALL assert out_valid for exactly one cycle per accepted op, including CLR; otherwise 0.
REQ-022 SHALL hold C, ovf, op_cnt unchanged while in_valid=0; op, A, B are don't-care then.
REQ-023 SHALL increment op_cnt per accepted op, wrapping 255 -> 0.
REQ-024 SHALL treat back-to-back ACC ops as chained: each uses the C produced by the previous edge.

Reset
REQ-025 SHALL, when reset=0, asynchronously force C=0, out_valid=0, ovf=0, op_cnt=0, independent of clk.
REQ-026 SHALL discard any op sampled in the same cycle reset is asserted; no out_valid follows it.
REQ-027 SHALL accept the first op on the first rising edge after reset deasserts.

Verification (WIDTH=4, SAT_EN=1 unless noted)
REQ-028 SHALL verify reset: reset=0 mid-stream with C=14 -> C=0, ovf=0, op_cnt=0, out_valid=0 immediately, before the next clk edge.
REQ-029 SHALL verify ADD/SUB corners: ADD -8,-8 -> C=-16; ADD 7,7 -> 14; SUB 7,-8 -> 15; SUB -8,7 -> -15; ADD 0,0 -> 0; each gives one out_valid pulse.
REQ-030 SHALL verify positive saturation: ADD 7,7 (C=14), then ACC A=7 -> C=15, ovf=1; ADD 0,0 -> C=0, ovf stays 1; CLR -> C=0, ovf=0.
REQ-031 SHALL verify negative saturation and wrap: ADD -8,-8 (C=-16), then ACC A=-1 -> C=-16, ovf=1; with SAT_EN=0 the same sequence -> C=15, ovf=1.
REQ-032 SHALL verify hold: in_valid=0 for 5 cycles with random op/A/B -> C, ovf, op_cnt constant; out_valid=0.
REQ-033 SHALL verify counting: 256 consecutive valid ADD ops -> op_cnt wraps to 0; C correct each cycle against a reference model.
